// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture sequencer: strobed sampling of DW channels into a circular RAM with a
// pre-trigger window, a selectable trigger condition and a post-trigger fill.
module la_capture_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          trigger_en,
  input  logic          cap_abort,
  input  logic [2:0]    cpu_chn_sel,
  input  logic [2:0]    cpu_mode_sel,
  input  logic [3:0]    cpu_freq_sel,
  input  logic [AW-1:0] pre_len,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] start_addr,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StWait = 3'd2,
    StPost = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_s1_q, data_s2_q;
  logic          trig_s_q, trig_d_q;
  logic [2:0]    chn_q, chn_d, mode_q, mode_d;
  logic [3:0]    freq_q, freq_d;
  logic [AW-1:0] pre_q, pre_d;
  logic [15:0]   div_q, div_d;
  logic [AW-1:0] ptr_q, ptr_d, smp_q, smp_d;
  logic          prev_q, prev_d, prev_vld_q, prev_vld_d;
  logic          wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, trig_addr_q, trig_addr_d, start_addr_q, start_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic          arm, active, strobe, cur, trig_hit;
  logic [15:0]   div_mask;
  logic [AW-1:0] post_len;

  always_comb begin
    arm      = trig_s_q & ~trig_d_q;
    active   = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
    div_mask = (16'd1 << freq_q) - 16'd1;
    strobe   = active && (div_q == div_mask);
    cur      = data_s2_q[chn_q];
    // pre_len is AW bits wide, so it can never exceed DEPTH-1; the clamp is implicit.
    post_len = ~pre_q;
    case (mode_q)
      3'd0:    trig_hit = prev_vld_q & ~prev_q & cur;
      3'd1:    trig_hit = prev_vld_q & prev_q & ~cur;
      3'd2:    trig_hit = prev_vld_q & (prev_q ^ cur);
      3'd3:    trig_hit = cur;
      3'd4:    trig_hit = ~cur;
      default: trig_hit = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    chn_d        = chn_q;
    mode_d       = mode_q;
    freq_d       = freq_q;
    pre_d        = pre_q;
    div_d        = div_q;
    ptr_d        = ptr_q;
    smp_d        = smp_q;
    prev_d       = prev_q;
    prev_vld_d   = prev_vld_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    if (cap_abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            chn_d      = cpu_chn_sel;
            mode_d     = cpu_mode_sel;
            freq_d     = cpu_freq_sel;
            pre_d      = pre_len;
            div_d      = '0;
            ptr_d      = '0;
            smp_d      = '0;
            wr_addr_d  = '0;
            prev_vld_d = 1'b0;
            state_d    = (pre_len == '0) ? StWait : StPre;
          end
        end
        StPre, StWait, StPost: begin
          div_d = strobe ? 16'd0 : div_q + 16'd1;
          if (strobe) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = data_s2_q;
            ptr_d      = ptr_q + AW'(1);
            prev_d     = cur;
            prev_vld_d = 1'b1;
            if (state_q == StPre) begin
              if (smp_q == pre_q - AW'(1)) begin
                smp_d   = '0;
                state_d = StWait;
              end else begin
                smp_d = smp_q + AW'(1);
              end
            end else if (state_q == StWait) begin
              if (trig_hit) begin
                trig_addr_d  = ptr_q;
                start_addr_d = ptr_q - pre_q;
                smp_d        = '0;
                state_d      = (post_len == '0) ? StDone : StPost;
              end
            end else begin
              if (smp_q == post_len - AW'(1)) begin
                state_d = StDone;
              end else begin
                smp_d = smp_q + AW'(1);
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StPre) || (state_d == StWait) || (state_d == StPost);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      trig_s_q     <= 1'b0;
      trig_d_q     <= 1'b0;
      chn_q        <= '0;
      mode_q       <= '0;
      freq_q       <= '0;
      pre_q        <= '0;
      div_q        <= '0;
      ptr_q        <= '0;
      smp_q        <= '0;
      prev_q       <= 1'b0;
      prev_vld_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      data_s1_q    <= data_in;
      data_s2_q    <= data_s1_q;
      trig_s_q     <= trigger_en;
      trig_d_q     <= trig_s_q;
      chn_q        <= chn_d;
      mode_q       <= mode_d;
      freq_q       <= freq_d;
      pre_q        <= pre_d;
      div_q        <= div_d;
      ptr_q        <= ptr_d;
      smp_q        <= smp_d;
      prev_q       <= prev_d;
      prev_vld_q   <= prev_vld_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign state      = state_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl at DEPTH=16: expected RAM writes are queued by the stimulus and
// consumed by an independent write monitor; status outputs are checked after each capture.
module tb_la_capture_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          trigger_en = 1'b0;
  logic          cap_abort = 1'b0;
  logic [2:0]    cpu_chn_sel = '0;
  logic [2:0]    cpu_mode_sel = '0;
  logic [3:0]    cpu_freq_sel = '0;
  logic [AW-1:0] pre_len = '0;
  logic          wr_en, busy, done;
  logic [AW-1:0] wr_addr, trig_addr, start_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    state;

  la_capture_ctrl #(.DW(DW), .AW(AW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .data_in      (data_in),
    .trigger_en   (trigger_en),
    .cap_abort    (cap_abort),
    .cpu_chn_sel  (cpu_chn_sel),
    .cpu_mode_sel (cpu_mode_sel),
    .cpu_freq_sel (cpu_freq_sel),
    .pre_len      (pre_len),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .trig_addr    (trig_addr),
    .start_addr   (start_addr),
    .state        (state)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_wr_cyc = -1;
  int  exp_gap = 1;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM write must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
        if (last_wr_cyc >= 0) check("wr_gap", cyc - last_wr_cyc, exp_gap);
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  // Sample n of a capture is data_in as driven before clock edge 2^freq*(n+1) after arming.
  task automatic push_writes(input int nwr, input int t, input int step_k,
                             input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    wr_t w;
    for (int n = 0; n < nwr; n++) begin
      w.addr = AW'(n);
      w.data = (t * (n + 1) >= step_k) ? v1 : v0;
      exp_q.push_back(w);
    end
  endtask

  task automatic run(input string name, input logic [2:0] chn, input logic [2:0] mode,
                     input logic [3:0] freq, input logic [AW-1:0] pre, input int step_k,
                     input logic [DW-1:0] v0, input logic [DW-1:0] v1, input int nwr,
                     input int ncyc, input int exp_trig, input int exp_start);
    int t;
    t = 1 << freq;
    push_writes(nwr, t, step_k, v0, v1);
    exp_gap     = t;
    last_wr_cyc = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        cpu_chn_sel  = chn;
        cpu_mode_sel = mode;
        cpu_freq_sel = freq;
        pre_len      = pre;
        trigger_en   = 1'b1;
      end
      // Configuration changes mid-capture must be ignored.
      if (k == 20) begin
        cpu_freq_sel = 4'd0;
        cpu_mode_sel = 3'd5;
        cpu_chn_sel  = ~chn;
        pre_len      = '0;
      end
      data_in = (k >= step_k) ? v1 : v0;
    end
    trigger_en = 1'b0;
    check({name, "_done"}, 32'(done), 1);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_state"}, 32'(state), 4);
    check({name, "_trig_addr"}, 32'(trig_addr), exp_trig);
    check({name, "_start_addr"}, 32'(start_addr), exp_start);
    check({name, "_pending"}, exp_q.size(), 0);
    idle(3);
  endtask

  initial begin
    #12;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_trig_addr", 32'(trig_addr), 0);
    check("rst_start_addr", 32'(start_addr), 0);
    check("rst_state", 32'(state), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(3);

    // Rising edge on ch2 at sample 9: 4 pre, 6 wait, 11 post writes, wrapping 15->0.
    run("rise", 3'd2, 3'd0, 4'd0, 4'd4, 10, 8'h41, 8'h45, 21, 30, 9, 5);
    // Immediate trigger with no pre window.
    run("immed", 3'd0, 3'd5, 4'd0, 4'd0, 6, 8'h12, 8'h34, 16, 25, 0, 0);
    // Strobe every 8 clocks, high level on ch0 first seen at sample 4.
    run("slow", 3'd0, 3'd3, 4'd3, 4'd2, 33, 8'hF0, 8'hF1, 18, 155, 4, 2);
    // Maximum pre window, line already high: trigger on first wait sample, no post samples.
    run("maxpre", 3'd7, 3'd3, 4'd0, 4'd15, 1, 8'h80, 8'h80, 16, 25, 15, 0);

    // Abort in WAIT together with a new arm edge.
    push_writes(7, 1, 1, 8'h00, 8'h00);
    exp_gap     = 1;
    last_wr_cyc = -1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        cpu_chn_sel  = 3'd1;
        cpu_mode_sel = 3'd0;
        cpu_freq_sel = 4'd0;
        pre_len      = 4'd2;
        trigger_en   = 1'b1;
      end
      if (k == 5) trigger_en = 1'b0;
      if (k == 9) trigger_en = 1'b1;
      cap_abort = (k == 10);
      data_in   = 8'h00;
    end
    trigger_en = 1'b0;
    check("abort_state", 32'(state), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_wr_en", 32'(wr_en), 0);
    idle(4);
    check("abort_pending", exp_q.size(), 0);
    check("abort_trig_hold", 32'(trig_addr), 15);
    check("abort_start_hold", 32'(start_addr), 0);
    // Re-arm after abort starts again at address 0; low level on ch1.
    run("rearm", 3'd1, 3'd4, 4'd0, 4'd3, 1, 8'h00, 8'h00, 16, 25, 3, 0);

    // Falling edge on ch3, arm edge while busy, then reset mid-POST.
    push_writes(9, 1, 5, 8'h08, 8'h00);
    exp_gap     = 1;
    last_wr_cyc = -1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        cpu_chn_sel  = 3'd3;
        cpu_mode_sel = 3'd1;
        cpu_freq_sel = 4'd0;
        pre_len      = 4'd1;
        trigger_en   = 1'b1;
      end
      if (k == 7) trigger_en = 1'b0;
      if (k == 9) trigger_en = 1'b1;
      data_in = (k >= 5) ? 8'h00 : 8'h08;
    end
    check("busyarm_trig_addr", 32'(trig_addr), 4);
    check("busyarm_start_addr", 32'(start_addr), 3);
    check("busyarm_state", 32'(state), 3);
    check("busyarm_busy", 32'(busy), 1);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mrst_wr_en", 32'(wr_en), 0);
    check("mrst_wr_addr", 32'(wr_addr), 0);
    check("mrst_wr_data", 32'(wr_data), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_trig_addr", 32'(trig_addr), 0);
    check("mrst_start_addr", 32'(start_addr), 0);
    check("mrst_state", 32'(state), 0);
    check("mrst_pending", exp_q.size(), 0);
    trigger_en = 1'b0;
    idle(2);
    sys_rst_n = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
